// File: rtl/spec_line_sched.sv
// spec_line_sched: per-line analysis scheduler (frame snapshot, read-address sequencing, freeze handshake).
// Define SPEC_LINE_SCHED_OVRCNT_EN to add the saturating OVR_COUNT overrun counter output.
module spec_line_sched #(
    parameter int ABIT      = 12,
    parameter int OFFSET    = 402,
    parameter int WIN_LEN   = 3200,
    parameter int PRIME_CYC = 2,
    parameter int DRAIN_CYC = 4
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            FRAME_START,
    input  logic            LINE_START,
    input  logic [ABIT:0]   WADR,
    input  logic            FREEZE_REQ,
    output logic            FREEZE_ACK,
    output logic [ABIT-1:0] RADR,
    output logic            NCO_START,
    output logic            ACC_CLR,
    output logic            WIN_VALID,
    output logic            LINE_DONE,
    output logic            BUSY,
    output logic            OVERRUN
`ifdef SPEC_LINE_SCHED_OVRCNT_EN
    ,
    output logic [15:0]     OVR_COUNT
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_r;
    logic [31:0]     phase_cnt_r;
    logic [ABIT-1:0] addr_left_r;
    logic [ABIT-1:0] radr_r;
    logic [ABIT-1:0] snap_r;
    logic            freeze_r;
    logic            nco_start_r;
    logic            acc_clr_r;
    logic            win_valid_r;
    logic            line_done_r;
    logic            busy_r;
    logic            overrun_r;

    logic            snap_upd_s;
    logic [ABIT-1:0] eff_snap_s;
    logic [ABIT-1:0] base_s;
    logic            ovr_hit_s;
    logic            unused_bank_s;

    // The bank-select LSB of the write pointer plays no part in pair addressing.
    assign unused_bank_s = WADR[0];

    // Effective snapshot with same-cycle FRAME_START bypass, and the derived read base.
    always_comb begin
        snap_upd_s = FRAME_START & ~FREEZE_REQ;
        if (snap_upd_s) begin
            eff_snap_s = WADR[ABIT:1];
        end else begin
            eff_snap_s = snap_r;
        end
        base_s    = eff_snap_s + ABIT'(OFFSET);
        ovr_hit_s = LINE_START & (state_r != ST_IDLE);
    end

    // Snapshot and freeze state; both only move on FRAME_START.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            snap_r   <= {ABIT{1'b0}};
            freeze_r <= 1'b0;
        end else if (FRAME_START) begin
            snap_r   <= eff_snap_s;
            freeze_r <= FREEZE_REQ;
        end else begin
            snap_r   <= snap_r;
            freeze_r <= freeze_r;
        end
    end

    // Line sequencer: PRIME -> RUN -> DRAIN with registered strobes and address stream.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= ST_IDLE;
            phase_cnt_r <= 32'd0;
            addr_left_r <= {ABIT{1'b0}};
            radr_r      <= {ABIT{1'b0}};
            nco_start_r <= 1'b0;
            acc_clr_r   <= 1'b0;
            win_valid_r <= 1'b0;
            line_done_r <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            nco_start_r <= 1'b0;
            acc_clr_r   <= 1'b0;
            line_done_r <= 1'b0;
            overrun_r   <= ovr_hit_s;
            // Address stream runs independently of the phase, stopping after WIN_LEN addresses.
            if ((state_r != ST_IDLE) && (addr_left_r != {ABIT{1'b0}})) begin
                radr_r      <= radr_r + ABIT'(1);
                addr_left_r <= addr_left_r - ABIT'(1);
            end else begin
                radr_r      <= radr_r;
                addr_left_r <= addr_left_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (LINE_START) begin
                        state_r     <= ST_PRIME;
                        phase_cnt_r <= 32'(PRIME_CYC - 1);
                        radr_r      <= base_s;
                        addr_left_r <= ABIT'(WIN_LEN - 1);
                        nco_start_r <= 1'b1;
                        acc_clr_r   <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    if (phase_cnt_r == 32'd0) begin
                        state_r     <= ST_RUN;
                        win_valid_r <= 1'b1;
                        phase_cnt_r <= 32'(WIN_LEN - 1);
                    end else begin
                        phase_cnt_r <= phase_cnt_r - 32'd1;
                    end
                end
                ST_RUN: begin
                    if (phase_cnt_r == 32'd0) begin
                        state_r     <= ST_DRAIN;
                        win_valid_r <= 1'b0;
                        phase_cnt_r <= 32'(DRAIN_CYC - 1);
                        line_done_r <= (DRAIN_CYC == 1);
                    end else begin
                        phase_cnt_r <= phase_cnt_r - 32'd1;
                    end
                end
                ST_DRAIN: begin
                    if (phase_cnt_r == 32'd0) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        phase_cnt_r <= phase_cnt_r - 32'd1;
                        line_done_r <= (phase_cnt_r == 32'd1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    win_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPEC_LINE_SCHED_OVRCNT_EN
    logic [15:0] ovr_count_r;

    // Saturating overrun counter, cleared only by reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovr_count_r <= 16'd0;
        end else if (ovr_hit_s && (ovr_count_r != 16'hFFFF)) begin
            ovr_count_r <= ovr_count_r + 16'd1;
        end else begin
            ovr_count_r <= ovr_count_r;
        end
    end

    assign OVR_COUNT = ovr_count_r;
`endif

    assign FREEZE_ACK = freeze_r;
    assign RADR       = radr_r;
    assign NCO_START  = nco_start_r;
    assign ACC_CLR    = acc_clr_r;
    assign WIN_VALID  = win_valid_r;
    assign LINE_DONE  = line_done_r;
    assign BUSY       = busy_r;
    assign OVERRUN    = overrun_r;

endmodule

// File: tb/tb_spec_line_sched.sv
// Self-checking bench for spec_line_sched: cycle-accurate line model plus directed literal checks.
module tb_spec_line_sched;

    localparam int P   = 2;
    localparam int W   = 3200;
    localparam int D   = 4;
    localparam int OFF = 402;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        FRAME_START;
    logic        LINE_START;
    logic [12:0] WADR;
    logic        FREEZE_REQ;
    logic        FREEZE_ACK;
    logic [11:0] RADR;
    logic        NCO_START;
    logic        ACC_CLR;
    logic        WIN_VALID;
    logic        LINE_DONE;
    logic        BUSY;
    logic        OVERRUN;
`ifdef SPEC_LINE_SCHED_OVRCNT_EN
    logic [15:0] OVR_COUNT;
`endif

    spec_line_sched dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .FRAME_START (FRAME_START),
        .LINE_START  (LINE_START),
        .WADR        (WADR),
        .FREEZE_REQ  (FREEZE_REQ),
        .FREEZE_ACK  (FREEZE_ACK),
        .RADR        (RADR),
        .NCO_START   (NCO_START),
        .ACC_CLR     (ACC_CLR),
        .WIN_VALID   (WIN_VALID),
        .LINE_DONE   (LINE_DONE),
        .BUSY        (BUSY),
        .OVERRUN     (OVERRUN)
`ifdef SPEC_LINE_SCHED_OVRCNT_EN
        ,
        .OVR_COUNT   (OVR_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model state: the current/last line is its start cycle and base address.
    int have_line = 0;
    int lt        = 0;
    int lbase     = 0;
    int m_snap    = 0;
    int m_freeze  = 0;
    int ovr_pend  = 0;
    int k, e_radr, eff, act;

    initial begin
        forever begin
            @(negedge CLK);
            if (!nRST) begin
                have_line = 0;
                m_snap    = 0;
                m_freeze  = 0;
                ovr_pend  = 0;
            end
            k      = cyc - lt;
            act    = (have_line != 0 && k >= 1 && k <= P + W + D) ? 1 : 0;
            e_radr = (have_line != 0 && k >= 1) ? (lbase + ((k - 1 < W - 1) ? k - 1 : W - 1)) % 4096 : 0;
            chk("BUSY",       int'(BUSY),       act);
            chk("RADR",       int'(RADR),       e_radr);
            chk("NCO_START",  int'(NCO_START),  (act != 0 && k == 1) ? 1 : 0);
            chk("ACC_CLR",    int'(ACC_CLR),    (act != 0 && k == 1) ? 1 : 0);
            chk("WIN_VALID",  int'(WIN_VALID),  (act != 0 && k >= P + 1 && k <= P + W) ? 1 : 0);
            chk("LINE_DONE",  int'(LINE_DONE),  (act != 0 && k == P + W + D) ? 1 : 0);
            chk("OVERRUN",    int'(OVERRUN),    ovr_pend);
            chk("FREEZE_ACK", int'(FREEZE_ACK), m_freeze);
            if (nRST) begin
                ovr_pend = (LINE_START && act != 0) ? 1 : 0;
                if (LINE_START && act == 0) begin
                    eff       = (FRAME_START && !FREEZE_REQ) ? int'(WADR[12:1]) : m_snap;
                    have_line = 1;
                    lt        = cyc;
                    lbase     = (eff + OFF) % 4096;
                end
                if (FRAME_START) begin
                    m_freeze = FREEZE_REQ ? 1 : 0;
                    if (!FREEZE_REQ) m_snap = int'(WADR[12:1]);
                end
            end
            cyc++;
        end
    end

    task automatic frame(input logic [12:0] w, input logic req);
        @(posedge CLK); #1;
        FREEZE_REQ = req; FRAME_START = 1'b1; WADR = w;
        @(posedge CLK); #1;
        FRAME_START = 1'b0;
    endtask

    // Leaves the caller at the negedge of cycle t+1.
    task automatic start_line(input logic fs, input logic [12:0] w);
        @(posedge CLK); #1;
        FRAME_START = fs; LINE_START = 1'b1; WADR = w;
        @(posedge CLK); #1;
        FRAME_START = 1'b0; LINE_START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic pulse_line();
        @(posedge CLK); #1;
        LINE_START = 1'b1;
        @(posedge CLK); #1;
        LINE_START = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (BUSY && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, int'(BUSY), 0);
    endtask

    initial begin
        int nv, first, n;
        nRST = 1'b0; FRAME_START = 1'b0; LINE_START = 1'b0; WADR = 13'h0000; FREEZE_REQ = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_radr", int'(RADR), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_ack",  int'(FREEZE_ACK), 0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // 1: basic line, base 0x080 + 402
        frame(13'h0100, 1'b0);
        start_line(1'b0, 13'h0000);
        chk("T1_radr_base", int'(RADR), 12'h212);
        chk("T1_nco",       int'(NCO_START), 1);
        chk("T1_accclr",    int'(ACC_CLR), 1);
        nv = 0; first = 0;
        for (int i = 1; i <= 3207; i++) begin
            if (i > 1) @(negedge CLK);
            if (WIN_VALID) begin
                nv++;
                if (first == 0) first = i;
            end
            if (i == 3206) chk("T1_done_t3206", int'(LINE_DONE), 1);
            if (i == 3207) chk("T1_busy_low_t3207", int'(BUSY), 0);
        end
        chk("T1_valid_len", nv, 3200);
        chk("T1_valid_first", first, 3);

        // 2: snapshot 0xF80 gives base 0x112
        frame(13'h1F00, 1'b0);
        start_line(1'b0, 13'h0000);
        chk("T2_radr_base", int'(RADR), 12'h112);
        wait_idle("T2_idle");

        // 3: base 0xF92 wraps; overruns mid-line and on the LINE_DONE cycle
        frame(13'h1C00, 1'b0);
        start_line(1'b0, 13'h0000);
        chk("T3_radr_base", int'(RADR), 12'hF92);
        repeat (109) @(negedge CLK);
        chk("T3_radr_fff", int'(RADR), 12'hFFF);
        @(negedge CLK);
        chk("T3_radr_wrap0", int'(RADR), 12'h000);
        pulse_line();
        @(negedge CLK);
        chk("T3_overrun", int'(OVERRUN), 1);
        chk("T3_no_nco", int'(NCO_START), 0);
        n = 0;
        @(posedge CLK); #1;
        while (!LINE_DONE && n < 4000) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("T3_done_seen", int'(LINE_DONE), 1);
        LINE_START = 1'b1;
        @(posedge CLK); #1;
        LINE_START = 1'b0;
        @(negedge CLK);
        chk("T3_ovr_at_done", int'(OVERRUN), 1);
        chk("T3_idle_after", int'(BUSY), 0);

        // 4: freeze holds snapshot 0x080 across a new frame, release takes 0x400
        frame(13'h0100, 1'b0);
        frame(13'h0100, 1'b1);
        @(negedge CLK);
        chk("T4_ack_on", int'(FREEZE_ACK), 1);
        frame(13'h0800, 1'b1);
        start_line(1'b0, 13'h0000);
        chk("T4_frozen_base", int'(RADR), 12'h212);
        wait_idle("T4a_idle");
        @(posedge CLK); #1;
        FREEZE_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        chk("T4_req_toggle_no_effect", int'(FREEZE_ACK), 1);
        frame(13'h0800, 1'b0);
        @(negedge CLK);
        chk("T4_ack_off", int'(FREEZE_ACK), 0);
        start_line(1'b0, 13'h0000);
        chk("T4_unfrozen_base", int'(RADR), 12'h592);
        repeat (50) @(negedge CLK);
        frame(13'h0000, 1'b0);
        wait_idle("T4b_idle");

        // 5: FRAME_START and LINE_START together use the new snapshot
        start_line(1'b1, 13'h0200);
        chk("T5_bypass_base", int'(RADR), 12'h292);

        // 6: reset mid-RUN, then a fresh line from a zero snapshot
        repeat (1000) @(negedge CLK);
        chk("T6_in_run", int'(WIN_VALID), 1);
        @(posedge CLK); #1;
        nRST = 1'b0;
        #1;
        chk("T6_rst_radr", int'(RADR), 0);
        chk("T6_rst_busy", int'(BUSY), 0);
        chk("T6_rst_valid", int'(WIN_VALID), 0);
        @(posedge CLK); #1;
        nRST = 1'b1;
        start_line(1'b0, 13'h0000);
        chk("T6_fresh_base", int'(RADR), 12'h192);
        chk("T6_fresh_nco", int'(NCO_START), 1);
        repeat (3) pulse_line();
        @(negedge CLK);
`ifdef SPEC_LINE_SCHED_OVRCNT_EN
        chk("T6_ovr_count3", int'(OVR_COUNT), 3);
`endif
        wait_idle("T6_idle");
        @(posedge CLK); #1;
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(negedge CLK);
`ifdef SPEC_LINE_SCHED_OVRCNT_EN
        chk("T6_ovr_count_rst", int'(OVR_COUNT), 0);
`endif
        chk("T6_final_radr", int'(RADR), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
